// File: rtl/wait_fee_calc.sv
// wait_fee_calc
// Converts the waiting-minute count of the taxi meter into a waiting fee.
// The first FREE_MIN minutes are free, every further minute costs RATE units,
// and the fee saturates at 10^DIGITS-1. Each recomputation runs a serial
// double-dabble conversion that produces a packed-BCD copy for the display.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     trip active; low clears the block like reset
//   minute    waiting minutes from the wait-time counter
//   fee_bin   binary saturated fee
//   fee_bcd   packed BCD fee, most significant digit at the top
//   fee_valid one-cycle pulse when fee_bcd is updated
//   busy      conversion in progress
//   overflow  sticky flag, fee has saturated
module wait_fee_calc #(
  parameter int FREE_MIN = 3,
  parameter int RATE     = 5,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           minute,
  output logic [15:0]           fee_bin,
  output logic [4*DIGITS-1:0]   fee_bcd,
  output logic                  fee_valid,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [31:0] FEE_MAX = 32'(10**DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2
  } state_t;

  // Add 3 to every BCD digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [4*DIGITS-1:0] dabble_adjust(input logic [4*DIGITS-1:0] acc);
    logic [4*DIGITS-1:0] res;
    res = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (res[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = res[4*d +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  state_t              state_r;
  logic [15:0]         last_min_r;
  logic [15:0]         shift_r;
  logic [4*DIGITS-1:0] bcd_acc_r;
  logic [3:0]          bit_cnt_r;

  logic [15:0]         billable_s;
  logic [31:0]         product_s;
  logic                sat_s;
  logic [15:0]         fee_sat_s;
  logic [4*DIGITS-1:0] adj_s;
  logic [4*DIGITS-1:0] bcd_next_s;

  // Fee arithmetic on the latched minute and one double-dabble step.
  always_comb begin
    billable_s = 16'd0;
    if (last_min_r > 16'(FREE_MIN)) begin
      billable_s = last_min_r - 16'(FREE_MIN);
    end else begin
      billable_s = 16'd0;
    end
    // 16-bit minutes times a small rate always fit in 32 bits.
    product_s = 32'(billable_s) * 32'(RATE);
    sat_s     = (product_s > FEE_MAX);
    if (sat_s) begin
      fee_sat_s = FEE_MAX[15:0];
    end else begin
      fee_sat_s = product_s[15:0];
    end
    adj_s      = dabble_adjust(bcd_acc_r);
    bcd_next_s = {adj_s[4*DIGITS-2:0], shift_r[15]};
  end

  // Control FSM with registered outputs; start low acts as a clear.
  always_ff @(posedge clk) begin
    if (reset || !start) begin
      state_r    <= IDLE;
      last_min_r <= 16'd0;
      shift_r    <= 16'd0;
      bcd_acc_r  <= '0;
      bit_cnt_r  <= 4'd0;
      fee_bin    <= 16'd0;
      fee_bcd    <= '0;
      fee_valid  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      fee_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          // Only the live minute is compared, so changes seen during a
          // conversion collapse into one recomputation of the latest value.
          if (minute != last_min_r) begin
            last_min_r <= minute;
            busy       <= 1'b1;
            state_r    <= CALC;
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          fee_bin   <= fee_sat_s;
          shift_r   <= fee_sat_s;
          if (sat_s) begin
            overflow <= 1'b1;
          end else begin
            overflow <= overflow;
          end
          bcd_acc_r <= '0;
          bit_cnt_r <= 4'd0;
          state_r   <= CONV;
        end
        CONV: begin
          bcd_acc_r <= bcd_next_s;
          shift_r   <= {shift_r[14:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd15) begin
            fee_bcd   <= bcd_next_s;
            fee_valid <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
